// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
      ST_CSUM  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, bundled.
interface imem_loader_if #(
   parameter int AW = 6
);
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from accepted bytes; flags the cycle the 4th byte arrives.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  byte_idx_reg;
   // Only the three older bytes need storage; the newest one is taken straight from data.
   logic [23:0] shift_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_idx_reg <= 2'd0;
         shift_reg    <= 24'd0;
      end else if (clear) begin
         byte_idx_reg <= 2'd0;
         shift_reg    <= 24'd0;
      end else if (accept) begin
         byte_idx_reg <= byte_idx_reg + 2'd1;
         shift_reg    <= {data, shift_reg[23:8]};
      end
   end

   assign word       = {data, shift_reg};
   assign word_valid = accept && (byte_idx_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed byte-stream program image into instruction memory and
// keeps the core in reset until a good image is in place.
module imem_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
)(
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   imem_loader_if.master bus,
   output logic          core_reset_,
   output logic          busy,
   output logic          done,
   output logic          err
);

   state_t        state_reg, state_next;
   logic          in_ready_reg, in_ready_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;
   logic          core_reset_reg, core_reset_next;
   logic [7:0]    count_reg;
   logic [7:0]    word_cnt_reg;
   logic [7:0]    csum_reg;
   logic          mem_we_reg;
   logic [AW-1:0] mem_addr_reg;
   logic [31:0]   mem_wdata_reg;

   logic          accept;
   logic          count_bad;
   logic          last_word;
   logic [31:0]   word;
   logic          word_valid;

   assign accept    = bus.in_valid && in_ready_reg;
   assign count_bad = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH);
   assign last_word = (word_cnt_reg == count_reg - 8'd1);

   byte_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      ((state_reg == ST_COUNT) && accept),
      .accept     ((state_reg == ST_DATA) && accept),
      .data       (bus.in_data),
      .word       (word),
      .word_valid (word_valid)
   );

   // State and the status flags that are pure functions of it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         in_ready_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         core_reset_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         in_ready_reg   <= in_ready_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         err_reg        <= err_next;
         core_reset_reg <= core_reset_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERROR: if (load) state_next = ST_COUNT;
         ST_COUNT: if (accept) state_next = count_bad ? ST_ERROR : ST_DATA;
         ST_DATA:  if (word_valid && last_word) state_next = ST_CSUM;
         ST_CSUM:  if (accept) state_next = (bus.in_data == csum_reg) ? ST_DONE : ST_ERROR;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Flags are derived from the next state so they register alongside it.
   always_comb begin
      busy_next       = state_next inside {ST_COUNT, ST_DATA, ST_CSUM};
      in_ready_next   = busy_next;
      done_next       = (state_next == ST_DONE);
      err_next        = (state_next == ST_ERROR);
      core_reset_next = done_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg     <= 8'd0;
         word_cnt_reg  <= 8'd0;
         csum_reg      <= 8'd0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= 32'd0;
      end else begin
         mem_we_reg <= 1'b0;
         if ((state_reg == ST_COUNT) && accept) begin
            count_reg    <= bus.in_data;
            word_cnt_reg <= 8'd0;
            csum_reg     <= 8'd0;
         end
         if ((state_reg == ST_DATA) && accept) begin
            csum_reg <= csum_reg + bus.in_data;
         end
         if (word_valid) begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= word_cnt_reg[AW-1:0];
            mem_wdata_reg <= word;
            word_cnt_reg  <= word_cnt_reg + 8'd1;
         end
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign core_reset_   = core_reset_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign err           = err_reg;

endmodule
